// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
//   Shared types and helpers for the PWM duty-ramp controller.
//   - state_t     : controller FSM state (IDLE, RAMP)
//   - DUTY_W_DEF  : default duty/target width
//   - sat_inc / sat_dec / clamp_duty : saturating duty arithmetic on plain
//     integers; callers cast the result back to their own duty width.
package pwm_ctrl_pkg;

  localparam int DUTY_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  function automatic int sat_inc(input int d, input int max_d);
    return (d >= max_d) ? max_d : d + 1;
  endfunction

  function automatic int sat_dec(input int d);
    return (d <= 0) ? 0 : d - 1;
  endfunction

  function automatic int clamp_duty(input int d, input int max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer
//   PWM period counter plus ramp prescaler.
//   Ports:
//     clk, rst      : clock, async active-high reset
//     ramp_clr      : restart the prescaler (request accepted)
//     cnt           : position inside the PWM period, 0..PERIOD-1
//     wrap          : last cycle of the period
//     step_tick     : wrap that completes RAMP_DIV periods since the last clear
//     period_start  : first cycle of the period (cnt == 0)
module pwm_period_timer #(
  parameter int PERIOD   = 10,
  parameter int RAMP_DIV = 2,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ramp_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             step_tick,
  output logic             period_start
);

  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RAMP_DIV - 1);

  logic [RC_W-1:0] ramp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ramp_cnt <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // A clear coinciding with a wrap wins: that wrap does not count
      // toward the first step of the new ramp.
      if (ramp_clr)
        ramp_cnt <= '0;
      else if (wrap)
        ramp_cnt <= (ramp_cnt == RC_LAST) ? '0 : ramp_cnt + 1'b1;
    end
  end

  assign wrap         = (cnt == CNT_LAST);
  assign step_tick    = wrap && (ramp_cnt == RC_LAST);
  assign period_start = (cnt == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Duty-cycle sequencer: owns the PWM output, ramps duty one step per
//   RAMP_DIV periods toward a target taken from the host or from inc/dec
//   pulses. Duty only changes on the last cycle of a period, so the new
//   value applies from cnt == 0 and the output never glitches mid-period.
//   Ports:
//     clk, rst            : clock, async active-high reset
//     req_valid/req_ready : host target handshake (ready only in IDLE)
//     req_target          : requested duty, clamped to PERIOD
//     duty_inc/duty_dec   : single-cycle pulses, target = duty +/- 1
//     abort               : stop the ramp, keep the present duty
//     duty_out            : applied duty
//     busy / done         : ramping / one-cycle completion pulse
//     pwm_out             : cnt < duty_out
//     period_start        : cnt == 0
//   Build option: PWM_SOFTSTART_EN -- leave reset at duty 0 in RAMP and
//   ramp up to DEFAULT_DUTY.
//
//   state | meaning
//   IDLE  | duty held, accepting requests
//   RAMP  | stepping duty toward target on step_tick
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int PERIOD       = 10,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int RAMP_DIV     = 2,
  parameter int DEFAULT_DUTY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DUTY_W-1:0] req_target,
  input  logic              duty_inc,
  input  logic              duty_dec,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done,
  output logic              pwm_out,
  output logic              period_start
);

  localparam logic [DUTY_W-1:0] DEF_DUTY = DUTY_W'(DEFAULT_DUTY);

`ifdef PWM_SOFTSTART_EN
  localparam state_t            RST_STATE = RAMP;
  localparam logic [DUTY_W-1:0] RST_DUTY  = '0;
`else
  localparam state_t            RST_STATE = IDLE;
  localparam logic [DUTY_W-1:0] RST_DUTY  = DEF_DUTY;
`endif

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] cnt;
  logic              wrap;
  logic              step_tick;
  logic              inc_only;
  logic              dec_only;
  logic              accept;
  logic              unused_wrap;

  assign inc_only = duty_inc && !duty_dec;
  assign dec_only = duty_dec && !duty_inc;
  assign accept   = (state == IDLE) && (req_valid || inc_only || dec_only);

  pwm_period_timer #(
    .PERIOD   (PERIOD),
    .RAMP_DIV (RAMP_DIV),
    .CNT_W    (DUTY_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .ramp_clr     (accept),
    .cnt          (cnt),
    .wrap         (wrap),
    .step_tick    (step_tick),
    .period_start (period_start)
  );

  // The step decision only needs step_tick; wrap stays available on the timer.
  assign unused_wrap = wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      duty_out <= RST_DUTY;
      target   <= DEF_DUTY;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target <= DUTY_W'(clamp_duty(int'(req_target), PERIOD));
            state  <= RAMP;
          end else if (inc_only) begin
            target <= DUTY_W'(sat_inc(int'(duty_out), PERIOD));
            state  <= RAMP;
          end else if (dec_only) begin
            target <= DUTY_W'(sat_dec(int'(duty_out)));
            state  <= RAMP;
          end
        end
        RAMP: begin
          if (abort) begin
            target <= duty_out;
            state  <= IDLE;
          end else if (duty_out == target) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (step_tick) begin
            if (duty_out < target)
              duty_out <= DUTY_W'(sat_inc(int'(duty_out), PERIOD));
            else
              duty_out <= DUTY_W'(sat_dec(int'(duty_out)));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RAMP);
  assign req_ready = (state == IDLE);
  assign pwm_out   = (cnt < duty_out);

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer for the PWM generator. It owns the PWM period counter and the PWM output. Duty changes come from a valid/ready target interface (host) or from debounced inc/dec pulses. The block ramps duty one step per RAMP_DIV PWM periods toward the target and only updates duty at period boundaries, so the output never glitches mid-period.

Parameters:
PERIOD, 10, PWM period in clk cycles; also the maximum duty value (100%).
DUTY_W, 4, duty/target width; must hold PERIOD.
RAMP_DIV, 2, PWM periods per ramp step (>=1).
DEFAULT_DUTY, 5, duty value after reset (50%).

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous, active-high
req_valid  in  1  host target request
req_ready  out  1  high in IDLE only
req_target  in  DUTY_W  requested duty; clamped to PERIOD
duty_inc  in  1  debounced single-cycle pulse: target = duty+1
duty_dec  in  1  debounced single-cycle pulse: target = duty-1
abort  in  1  stop ramp, hold current duty
duty_out  out  DUTY_W  duty currently applied
busy  out  1  high in RAMP
done  out  1  one-cycle pulse on ramp completion
pwm_out  out  1  cnt < duty_out
period_start  out  1  high when cnt==0

Behaviour:
- Reset values: cnt=0, ramp_cnt=0, duty_out=DEFAULT_DUTY, target=DEFAULT_DUTY, state=IDLE, busy=0, done=0, req_ready=1.
- Period counter cnt runs 0..PERIOD-1 and wraps. wrap = (cnt==PERIOD-1).
- Ramp prescaler ramp_cnt counts wraps 0..RAMP_DIV-1. step_tick = wrap && ramp_cnt==RAMP_DIV-1. ramp_cnt clears on every request acceptance.
- pwm_out is combinational: cnt < duty_out. duty_out=0 gives constant low; duty_out=PERIOD gives constant high.
- IDLE state:
  - req_valid: target <= min(req_target, PERIOD); next state RAMP.
  - Otherwise duty_inc alone: target <= min(duty_out+1, PERIOD); next state RAMP.
  - Otherwise duty_dec alone: target <= max(duty_out-1, 0); next state RAMP.
  - duty_inc and duty_dec together: both ignored.
  - Priority: req_valid over inc/dec.
- RAMP state:
  - If duty_out==target: go to IDLE; done=1 for exactly the first IDLE cycle.
  - Else on step_tick: duty_out moves +/-1 toward target. The new value takes effect at cnt=0.
  - abort=1 (highest priority in RAMP): target <= duty_out, go to IDLE, no done pulse.
  - inc/dec/req_valid are ignored; req_ready=0.
- A request equal to the current duty goes to RAMP for one cycle, then IDLE with done.
- Latency: accept at cycle N puts the block in RAMP at N+1. The first step lands on the RAMP_DIV-th wrap after acceptance.
- Arithmetic is saturating. duty_out never leaves 0..PERIOD and never wraps.
- rst asserted mid-ramp: immediate return to reset values, regardless of clk.

Optional Feature:
Macro PWM_SOFTSTART_EN.
- Defined: reset gives duty_out=0, target=DEFAULT_DUTY, state=RAMP, busy=1, req_ready=0. The block ramps to DEFAULT_DUTY and pulses done on arrival. abort is honoured.
- Undefined: reset gives duty_out=DEFAULT_DUTY and state=IDLE, as above.

Decomposition:
- Package pwm_ctrl_pkg: state enum (IDLE, RAMP), DUTY_W default, saturating inc/dec and clamp functions.
- One sub-module, pwm_period_timer: owns cnt and ramp_cnt; outputs wrap, step_tick, period_start; has a ramp_clr input.
- The top level holds the FSM, duty/target registers and pwm_out compare.

Test Plan:
1. Release rst; no requests -> duty_out=5, pwm_out high for cnt 0..4 and low for 5..9, req_ready=1, busy=0, done never pulses.
2. req_target=8 accepted -> duty_out becomes 6, 7, 8 at 20-cycle intervals, each change at a cnt=0 boundary. req_ready=0 throughout. done pulses once, one cycle after the state leaves RAMP.
3. req_target=15 -> target clamped to 10; ramp ends with pwm_out constantly high. Then duty_inc -> duty stays 10 and done pulses.
4. Steady duty=0 plus duty_dec -> duty stays 0, done pulses. duty_inc and duty_dec in the same cycle -> no state change.
5. Ramp 5->9, abort asserted when duty_out=7 -> IDLE with duty_out=7, no done pulse, req_ready=1 the next cycle.
6. rst asserted between clk edges during a ramp -> all outputs at reset values immediately. With PWM_SOFTSTART_EN defined -> ramp 0->5 over 10 periods, then done.
